fifo_umbral: RTL and testbench
==============================

Name: fifo_umbral

Overview:
- Parametrised synchronous FIFO with runtime-programmable almost-empty/almost-full thresholds, a flow-control pause output and a sticky error flag.
- Generalises the team's fixed 6-bit FIFO to any data width and power-of-two depth.
- Correctly handles simultaneous push/pop and over/underflow.
- Sits between the master's data-producing logic and the downstream arbiter/demux. Pausa back-pressures the producer.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH entries
CNT_WIDTH, ADDR_WIDTH+1, width of occupancy count and thresholds (derived, not overridable)

Ports:
clk  input  1  single clock, all logic on rising edge
reset_L  input  1  asynchronous, active-low reset
push  input  1  write request
pop  input  1  read request
Fifo_Data_in  input  DATA_WIDTH  write data
Umbral_Bajo  input  CNT_WIDTH  almost-empty threshold
Umbral_Alto  input  CNT_WIDTH  almost-full threshold
Error_Clr  input  1  clears sticky Error_Fifo
Fifo_Data_out  output  DATA_WIDTH  read data, registered
Data_Valid  output  1  Fifo_Data_out holds a popped word this cycle
Fifo_Count  output  CNT_WIDTH  current occupancy, 0..DEPTH
Fifo_Empty  output  1  count == 0
Fifo_Full  output  1  count == DEPTH
Almost_Empty  output  1  count <= Umbral_Bajo
Almost_Full  output  1  count >= Umbral_Alto
Pausa  output  1  Almost_Full | Fifo_Full
Error_Fifo  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset_L low, asynchronous) sets the following values. The reset takes effect immediately, including mid-operation. Memory contents are not cleared.
  - wr_ptr=0, rd_ptr=0, count=0
  - Fifo_Data_out=0, Data_Valid=0
  - Fifo_Empty=1, Fifo_Full=0
  - Almost_Empty=1, Almost_Full=0, Pausa=0
  - Error_Fifo=0
- Accepted write: wr_en = push & (!Fifo_Full | pop_ok). The word is stored at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Accepted read: pop_ok = pop & !Fifo_Empty. Fifo_Data_out is loaded from mem[rd_ptr] on that edge, rd_ptr increments with wrap, and Data_Valid=1 the next cycle. Read latency is 1 cycle.
- When no read is accepted, Data_Valid=0 and Fifo_Data_out holds its last value.
- Count update:
  - +1 on write only
  - -1 on read only
  - unchanged when both are accepted or neither is
  - never leaves the 0..DEPTH range
- Push and pop together when full: both are accepted. The popped word is the oldest, the new word takes the freed slot, and count stays at DEPTH. No error.
- Push and pop together when empty: the push is accepted and the pop is rejected (no bypass). Count goes 0->1 and an underflow error is raised.
- Overflow: push while full without pop. The word is dropped, pointers and count are unchanged, and Error_Fifo is set.
- Underflow: pop while empty. Pointers are unchanged, Data_Valid=0, and Error_Fifo is set.
- Error_Fifo is sticky. It is cleared by Error_Clr or reset. If Error_Clr and a new error occur in the same cycle, the set wins.
- All status flags are registered and computed from count_next. They are valid in the same cycle as the updated Fifo_Count, with no extra lag.
- Thresholds are compared live each cycle, so a threshold change is reflected on the next edge.
  - Umbral_Alto=0 gives permanent Almost_Full.
  - Umbral_Bajo >= DEPTH gives permanent Almost_Empty.
  - Neither case is an error.
- Full/empty detection comes from count, not from pointer equality.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants
  - the derived DEPTH/CNT_WIDTH expressions
  - the error-cause encoding constants (ERR_NONE, ERR_OVF, ERR_UNF), for a future error-cause output
- One sub-module: reuse the existing dual_port_memory, instantiated with DATA_WIDTH, ADDR_WIDTH and MEM_SIZE = DEPTH-1.
  - Write enable: wr_en only. Read enable: pop_ok only. Raw push/pop never drive the memory.
- Control, count, flags and output register stay in fifo_umbral.

Test Plan:
- All tests use DATA_WIDTH=6, ADDR_WIDTH=2 (DEPTH=4), Umbral_Bajo=1, Umbral_Alto=3.
- Reset, then push 4 words 0x01..0x04:
  - Fifo_Count goes 1,2,3,4.
  - Almost_Empty drops after the 2nd push; Almost_Full and Pausa rise after the 3rd; Fifo_Full rises after the 4th.
  - Error_Fifo stays 0.
- From full, push 0x3F without pop: count stays 4 and Error_Fifo=1. Then pop 4 times: data out is 0x01,0x02,0x03,0x04, each with Data_Valid one cycle after its pop. 0x3F never appears.
- From empty, pop: Data_Valid=0, count=0, Error_Fifo=1. Pulse Error_Clr: Error_Fifo=0 next cycle.
- At full, push 0x2A and pop together for 5 cycles: count stays 4, no error, outputs 0x01..0x04 then 0x2A. Confirms pointer wrap.
- At empty, push 0x15 and pop together: count=1, Error_Fifo=1, Data_Valid=0. The next pop returns 0x15.
- Assert reset_L low asynchronously mid-burst at count=3: all flags return to reset values before the next clk edge. Then push 0x07, pop: output is 0x07.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the threshold FIFO (fifo_umbral) and its interface.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default geometry (6-bit words, 4 entries)
//   fifo_depth()                    : DEPTH = 2**ADDR_WIDTH
//   fifo_cnt_width()                : width of the occupancy count / thresholds
//   err_cause_e                     : error-cause encoding (reserved for a
//                                     future error-cause output)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 2;

  function automatic int fifo_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

  // One extra bit so that the count can represent DEPTH itself.
  function automatic int fifo_cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2
  } err_cause_e;

endpackage

// File: rtl/fifo_umbral_if.sv
// -----------------------------------------------------------------------------
// fifo_umbral_if
// Producer/consumer side signals of fifo_umbral grouped in one bundle.
//   master : producer / control side (drives push, pop, data in, thresholds,
//            Error_Clr; observes data out and all status flags)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface fifo_umbral_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  localparam int CNT_WIDTH = fifo_cnt_width(ADDR_WIDTH);

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] Fifo_Data_in;
  logic [CNT_WIDTH-1:0]  Umbral_Bajo;
  logic [CNT_WIDTH-1:0]  Umbral_Alto;
  logic                  Error_Clr;

  logic [DATA_WIDTH-1:0] Fifo_Data_out;
  logic                  Data_Valid;
  logic [CNT_WIDTH-1:0]  Fifo_Count;
  logic                  Fifo_Empty;
  logic                  Fifo_Full;
  logic                  Almost_Empty;
  logic                  Almost_Full;
  logic                  Pausa;
  logic                  Error_Fifo;

  modport master (
    output push, pop, Fifo_Data_in, Umbral_Bajo, Umbral_Alto, Error_Clr,
    input  Fifo_Data_out, Data_Valid, Fifo_Count, Fifo_Empty, Fifo_Full,
           Almost_Empty, Almost_Full, Pausa, Error_Fifo
  );

  modport slave (
    input  push, pop, Fifo_Data_in, Umbral_Bajo, Umbral_Alto, Error_Clr,
    output Fifo_Data_out, Data_Valid, Fifo_Count, Fifo_Empty, Fifo_Full,
           Almost_Empty, Almost_Full, Pausa, Error_Fifo
  );

endinterface

// File: rtl/dual_port_memory.sv
// -----------------------------------------------------------------------------
// dual_port_memory
// Simple storage array, one write port and one read port, single clock.
//   clk     : write clock
//   wr_en   : write strobe, stores wr_data at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe, rd_data is zero while low
//   rd_addr : read address
//   rd_data : combinational read data (old contents during a same-edge write)
// MEM_SIZE is the highest valid address. Contents are never reset.
// -----------------------------------------------------------------------------
module dual_port_memory #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int MEM_SIZE   = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_en ? mem[rd_addr] : '0;

endmodule

// File: rtl/fifo_umbral.sv
// -----------------------------------------------------------------------------
// fifo_umbral
// Synchronous FIFO with programmable almost-empty / almost-full thresholds,
// a back-pressure output (Pausa) and a sticky over/underflow flag.
//   clk     : single clock, rising edge
//   reset_L : asynchronous active-low reset
//   bus     : fifo_umbral_if.slave
//     push / pop / Fifo_Data_in      : write and read requests, write data
//     Umbral_Bajo / Umbral_Alto      : live almost-empty / almost-full levels
//     Error_Clr                      : clears Error_Fifo (a new error wins)
//     Fifo_Data_out / Data_Valid     : registered read data, 1-cycle latency
//     Fifo_Count                     : occupancy 0..DEPTH
//     Fifo_Empty / Fifo_Full         : count == 0 / count == DEPTH
//     Almost_Empty / Almost_Full     : count <= Umbral_Bajo / >= Umbral_Alto
//     Pausa                          : Almost_Full | Fifo_Full
//     Error_Fifo                     : sticky overflow / underflow
// All flags are registered from the next count, so they line up with
// Fifo_Count on the same cycle.
// -----------------------------------------------------------------------------
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset_L,
  fifo_umbral_if.slave  bus
);

  localparam int DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam int CNT_WIDTH = fifo_cnt_width(ADDR_WIDTH);

  localparam logic [CNT_WIDTH-1:0]  CNT_DEPTH = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_next;

  logic                  wr_en;
  logic                  pop_ok;
  logic                  err_set;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  empty_q;
  logic                  full_q;
  logic                  almost_empty_q;
  logic                  almost_full_q;
  logic                  pausa_q;
  logic                  error_q;

  // A pop on an empty FIFO is always rejected, even alongside a push: there
  // is no write-to-read bypass. A push on a full FIFO is accepted only when
  // a pop frees the oldest slot on the same edge.
  assign pop_ok  = bus.pop & ~empty_q;
  assign wr_en   = bus.push & (~full_q | pop_ok);
  assign err_set = (bus.push & ~wr_en) | (bus.pop & ~pop_ok);

  always_comb begin
    count_next = count;
    unique case ({wr_en, pop_ok})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  dual_port_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (DEPTH - 1)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.Fifo_Data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= pop_ok;
      if (pop_ok) begin
        data_out_q <= mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      pausa_q        <= 1'b0;
    end else begin
      empty_q        <= (count_next == '0);
      full_q         <= (count_next == CNT_DEPTH);
      almost_empty_q <= (count_next <= bus.Umbral_Bajo);
      almost_full_q  <= (count_next >= bus.Umbral_Alto);
      pausa_q        <= (count_next >= bus.Umbral_Alto) | (count_next == CNT_DEPTH);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error_q <= 1'b0;
    end else if (err_set) begin
      error_q <= 1'b1;
    end else if (bus.Error_Clr) begin
      error_q <= 1'b0;
    end
  end

  assign bus.Fifo_Data_out = data_out_q;
  assign bus.Data_Valid    = data_valid_q;
  assign bus.Fifo_Count    = count;
  assign bus.Fifo_Empty    = empty_q;
  assign bus.Fifo_Full     = full_q;
  assign bus.Almost_Empty  = almost_empty_q;
  assign bus.Almost_Full   = almost_full_q;
  assign bus.Pausa         = pausa_q;
  assign bus.Error_Fifo    = error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
module tb_fifo_umbral;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fifo_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Behavioural reference: a queue of stored words plus the expected
  // registered outputs after each edge.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_dv, m_err, m_empty, m_full, m_ae, m_af, m_pausa;
  int            m_cnt;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mq.delete();
      m_dout = '0; m_dv = 1'b0; m_err = 1'b0; m_cnt = 0;
      m_empty = 1'b1; m_full = 1'b0; m_ae = 1'b1; m_af = 1'b0; m_pausa = 1'b0;
    end else begin : model_step
      bit can_pop, can_push;
      can_pop  = bus.pop && (mq.size() != 0);
      can_push = bus.push && ((mq.size() < DEPTH) || can_pop);
      if (can_pop) m_dout = mq.pop_front();
      m_dv = can_pop;
      if (can_push) mq.push_back(bus.Fifo_Data_in);
      if ((bus.push && !can_push) || (bus.pop && !can_pop)) m_err = 1'b1;
      else if (bus.Error_Clr) m_err = 1'b0;
      m_cnt   = mq.size();
      m_empty = (m_cnt == 0);
      m_full  = (m_cnt == DEPTH);
      m_ae    = (m_cnt <= int'(bus.Umbral_Bajo));
      m_af    = (m_cnt >= int'(bus.Umbral_Alto));
      m_pausa = m_af || m_full;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_count", 32'(bus.Fifo_Count), 32'(m_cnt));
    check("cmp_dv", 32'(bus.Data_Valid), 32'(m_dv));
    check("cmp_dout", 32'(bus.Fifo_Data_out), 32'(m_dout));
    check("cmp_empty", 32'(bus.Fifo_Empty), 32'(m_empty));
    check("cmp_full", 32'(bus.Fifo_Full), 32'(m_full));
    check("cmp_ae", 32'(bus.Almost_Empty), 32'(m_ae));
    check("cmp_af", 32'(bus.Almost_Full), 32'(m_af));
    check("cmp_pausa", 32'(bus.Pausa), 32'(m_pausa));
    check("cmp_err", 32'(bus.Error_Fifo), 32'(m_err));
  end

  task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d, input logic c);
    bus.push = p; bus.pop = q; bus.Fifo_Data_in = d; bus.Error_Clr = c;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.Error_Clr = 1'b0;
  endtask

  // count, empty, full, almost_empty, almost_full, pausa, error
  task automatic chk_flags(input string name, input int cnt, input logic e, input logic f,
                           input logic ae, input logic af, input logic pa, input logic er);
    check({name, "_count"}, 32'(bus.Fifo_Count), 32'(cnt));
    check({name, "_empty"}, 32'(bus.Fifo_Empty), 32'(e));
    check({name, "_full"}, 32'(bus.Fifo_Full), 32'(f));
    check({name, "_ae"}, 32'(bus.Almost_Empty), 32'(ae));
    check({name, "_af"}, 32'(bus.Almost_Full), 32'(af));
    check({name, "_pausa"}, 32'(bus.Pausa), 32'(pa));
    check({name, "_err"}, 32'(bus.Error_Fifo), 32'(er));
  endtask

  task automatic chk_data(input string name, input logic dv, input logic [DW-1:0] d);
    check({name, "_dv"}, 32'(bus.Data_Valid), 32'(dv));
    check({name, "_dout"}, 32'(bus.Fifo_Data_out), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_seq [5];
    bus.push = 1'b0; bus.pop = 1'b0; bus.Fifo_Data_in = '0; bus.Error_Clr = 1'b0;
    bus.Umbral_Bajo = 3'd1; bus.Umbral_Alto = 3'd3;
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;

    chk_flags("reset", 0, 1, 0, 1, 0, 0, 0);
    chk_data("reset", 1'b0, 6'h00);

    cyc(1, 0, 6'h01, 0); chk_flags("push1", 1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 6'h02, 0); chk_flags("push2", 2, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 6'h03, 0); chk_flags("push3", 3, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 6'h04, 0); chk_flags("push4", 4, 0, 1, 0, 1, 1, 0);

    cyc(1, 0, 6'h3F, 0); chk_flags("ovf", 4, 0, 1, 0, 1, 1, 1);
    check("ovf_dv", 32'(bus.Data_Valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 6'h00, 0);
      chk_data("drain", 1'b1, 6'(i + 1));
      check("drain_count", 32'(bus.Fifo_Count), 32'(3 - i));
    end
    chk_flags("drained", 0, 1, 0, 1, 0, 0, 1);

    cyc(0, 0, 6'h00, 1); check("clr1_err", 32'(bus.Error_Fifo), 32'd0);
    cyc(0, 1, 6'h00, 0); chk_flags("unf", 0, 1, 0, 1, 0, 0, 1);
    chk_data("unf", 1'b0, 6'h04);
    cyc(0, 0, 6'h00, 1); check("clr2_err", 32'(bus.Error_Fifo), 32'd0);

    for (int i = 1; i <= 4; i++) cyc(1, 0, 6'(i), 0);
    exp_seq = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h2A};
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 6'h2A, 0);
      chk_data("fullpp", 1'b1, exp_seq[i]);
      chk_flags("fullpp", 4, 0, 1, 0, 1, 1, 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 6'h00, 0);
    check("drain2_count", 32'(bus.Fifo_Count), 32'd0);

    cyc(1, 1, 6'h15, 0);
    chk_flags("emptypp", 1, 0, 0, 1, 0, 0, 1);
    check("emptypp_dv", 32'(bus.Data_Valid), 32'd0);
    cyc(0, 1, 6'h00, 0); chk_data("emptypp_pop", 1'b1, 6'h15);
    cyc(0, 0, 6'h00, 1);

    for (int i = 0; i < 3; i++) cyc(1, 0, 6'(8 + i), 0);
    check("pre_rst_count", 32'(bus.Fifo_Count), 32'd3);
    bus.push = 1'b1; bus.Fifo_Data_in = 6'h0B;
    #2 reset_L = 1'b0;
    #1;
    chk_flags("async_rst", 0, 1, 0, 1, 0, 0, 0);
    chk_data("async_rst", 1'b0, 6'h00);
    bus.push = 1'b0;
    @(negedge clk); #1 reset_L = 1'b1;
    cyc(1, 0, 6'h07, 0);
    cyc(0, 1, 6'h00, 0); chk_data("post_rst", 1'b1, 6'h07);

    // Randomized phase: push/pop bias drifts so both full and empty regions
    // are visited; thresholds, clears and async resets are sprinkled in.
    begin
      int bias;
      bias = 50;
      for (int i = 0; i < 3000; i++) begin
        if ((i % 100) == 0) bias = $urandom_range(10, 90);
        if ($urandom_range(0, 31) == 0) begin
          bus.Umbral_Bajo = 3'($urandom_range(0, 7));
          bus.Umbral_Alto = 3'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 299) == 0) begin
          #($urandom_range(1, 3)) reset_L = 1'b0;
          @(negedge clk); #1 reset_L = 1'b1;
        end
        cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
            6'($urandom_range(0, 63)), $urandom_range(0, 15) == 0);
      end
    end

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
